// File: rtl/game_key_pkg.sv
// Shared constants for the game key controller: state codes and key indices.
package game_key_pkg;

   localparam logic [1:0] GS_IDLE  = 2'd0;
   localparam logic [1:0] GS_RUN   = 2'd1;
   localparam logic [1:0] GS_PAUSE = 2'd2;
   localparam logic [1:0] GS_OVER  = 2'd3;

   localparam int unsigned KEY_L   = 0;
   localparam int unsigned KEY_R   = 1;
   localparam int unsigned NUM_BTN = 2;

endpackage

// File: rtl/key_filt_edge.sv
// One key bit: 2-flop sample, FILT_CYC-sample level filter and rising-edge detect.
// A key that is high while reset is asserted stays blocked until it is seen low,
// so holding a key through reset never produces an edge.
module key_filt_edge #(
   parameter int unsigned FILT_CYC = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic level_o,
   output logic rise_c_o
);

   localparam int unsigned FCW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;

   logic           s1_q, s2_q;
   logic           filt_q, filt_d;
   logic           filt_dly_q;
   logic           blk_q;
   logic [FCW-1:0] cnt_q, cnt_d;

   // Sample register; the key register lives on the same clock.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= key_i;
         s2_q <= s1_q;
      end
   end

   // Count consecutive samples that disagree with the filtered level.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (s2_q != filt_q) begin
         if (cnt_q == FCW'(FILT_CYC - 1)) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + FCW'(1);
         end
      end
   end

   // Filter state, delayed level for edge detect, and hold-through-reset block.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         blk_q      <= key_i;
      end else begin
         cnt_q      <= cnt_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         blk_q      <= blk_q & key_i;
      end
   end

   assign level_o  = filt_q;
   assign rise_c_o = filt_q & ~filt_dly_q & ~blk_q;

endmodule

// File: rtl/game_key_ctrl.sv
// Game key controller: filtered key edges drive move pulses, the game state
// machine and the menu/game display toggle.
// Optional auto-repeat of move pulses: define GAME_KEY_AUTO_REPEAT_EN.
module game_key_ctrl
   import game_key_pkg::*;
#(
   parameter int unsigned FILT_CYC = 4,
   parameter int unsigned CNT_W    = 24,
   parameter int unsigned RPT_DLY  = 6_750_000,
   parameter int unsigned RPT_PER  = 2_700_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] mcu_btn,
   input  logic       mcu_str,
   input  logic       mcu_img,
   input  logic       game_over,
   output logic       move_l,
   output logic       move_r,
   output logic       run,
   output logic       show_game,
   output logic [1:0] gstate
);

   typedef enum logic [1:0] {
      ST_IDLE  = GS_IDLE,
      ST_RUN   = GS_RUN,
      ST_PAUSE = GS_PAUSE,
      ST_OVER  = GS_OVER
   } gstate_e;

   // Reject parameter sets the filter or the repeat counter cannot represent.
   if (FILT_CYC < 1 || RPT_DLY < 1 || RPT_PER < 1 || CNT_W < 2 || CNT_W > 31 ||
       RPT_DLY >= (32'd1 << CNT_W) || RPT_PER >= (32'd1 << CNT_W)) begin : g_bad_cfg
      $error("game_key_ctrl: invalid parameter set");
   end

   gstate_e            state_q, state_d;
   logic               show_q, show_d;
   logic               run_q, run_d;
   logic [NUM_BTN-1:0] move_q, move_d;
   logic [NUM_BTN-1:0] btn_lvl, btn_rise;
   logic [NUM_BTN-1:0] press_c, rpt_c;
   logic               str_rise, img_rise;
   logic               str_lvl_unused, img_lvl_unused;
   logic               in_run_c, both_c;

   // Filter and edge detect, one instance per key bit.
   for (genvar k = 0; k < NUM_BTN; k++) begin : g_btn
      key_filt_edge #(.FILT_CYC(FILT_CYC)) u_filt (
         .clk_i   (CLK),
         .rst_i   (RST),
         .key_i   (mcu_btn[k]),
         .level_o (btn_lvl[k]),
         .rise_c_o(btn_rise[k])
      );
   end

   key_filt_edge #(.FILT_CYC(FILT_CYC)) u_str (
      .clk_i   (CLK),
      .rst_i   (RST),
      .key_i   (mcu_str),
      .level_o (str_lvl_unused),
      .rise_c_o(str_rise)
   );

   key_filt_edge #(.FILT_CYC(FILT_CYC)) u_img (
      .clk_i   (CLK),
      .rst_i   (RST),
      .key_i   (mcu_img),
      .level_o (img_lvl_unused),
      .rise_c_o(img_rise)
   );

   assign in_run_c = (state_q == ST_RUN);
   assign both_c   = btn_lvl[KEY_L] & btn_lvl[KEY_R];
   assign press_c  = (in_run_c && !both_c) ? btn_rise : '0;

`ifdef GAME_KEY_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_BTN-1:0]            act_q, act_d;
   logic [NUM_BTN-1:0]            first_q, first_d;
   logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]              cnt_inc;

   // Repeat schedule per key: first period RPT_DLY after the press, then RPT_PER.
   always_comb begin
      act_d   = act_q;
      first_d = first_q;
      cnt_d   = cnt_q;
      rpt_c   = '0;
      cnt_inc = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         if (!in_run_c || !btn_lvl[k] || both_c) begin
            act_d[k]   = 1'b0;
            first_d[k] = 1'b0;
            cnt_d[k]   = '0;
         end else if (press_c[k]) begin
            act_d[k]   = 1'b1;
            first_d[k] = 1'b1;
            cnt_d[k]   = '0;
         end else if (act_q[k]) begin
            cnt_inc = (cnt_q[k] == CNT_MAX) ? cnt_q[k] : cnt_q[k] + CNT_W'(1);
            if (cnt_inc == (first_q[k] ? CNT_W'(RPT_DLY) : CNT_W'(RPT_PER))) begin
               rpt_c[k]   = 1'b1;
               first_d[k] = 1'b0;
               cnt_d[k]   = '0;
            end else begin
               cnt_d[k] = cnt_inc;
            end
         end
      end
   end

   // Repeat counter state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         act_q   <= '0;
         first_q <= '0;
         cnt_q   <= '0;
      end else begin
         act_q   <= act_d;
         first_q <= first_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign rpt_c = '0;
`endif

   // Game state, display select and move pulses.
   always_comb begin
      state_d = state_q;
      show_d  = img_rise ? ~show_q : show_q;
      move_d  = press_c | rpt_c;
      case (state_q)
         ST_IDLE: begin
            if (str_rise) begin
               state_d = ST_RUN;
               show_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (game_over)     state_d = ST_OVER;
            else if (str_rise) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (game_over)     state_d = ST_OVER;
            else if (str_rise) state_d = ST_RUN;
         end
         ST_OVER: begin
            if (str_rise) begin
               state_d = ST_IDLE;
               show_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      run_d = (state_d == ST_RUN);
   end

   // Output and state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         show_q  <= 1'b0;
         run_q   <= 1'b0;
         move_q  <= '0;
      end else begin
         state_q <= state_d;
         show_q  <= show_d;
         run_q   <= run_d;
         move_q  <= move_d;
      end
   end

   assign move_l    = move_q[KEY_L];
   assign move_r    = move_q[KEY_R];
   assign run       = run_q;
   assign show_game = show_q;
   assign gstate    = state_q;

endmodule

// File: tb/tb_game_key_ctrl.sv
// Bench for game_key_ctrl: directed vector table, hand sequences for repeat and
// reset corners, then random stimulus against a cycle-level behavioural model.
// Follows GAME_KEY_AUTO_REPEAT_EN the same way as the design.
module tb_game_key_ctrl;

   localparam int unsigned FILT_CYC = 4;
   localparam int unsigned CNT_W    = 24;
   localparam int unsigned RPT_DLY  = 20;
   localparam int unsigned RPT_PER  = 8;
`ifdef GAME_KEY_AUTO_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
`else
   localparam bit RPT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, str, img, go;
   logic [1:0] btn;
   logic       move_l, move_r, run, show_game;
   logic [1:0] gstate;

   game_key_ctrl #(
      .FILT_CYC(FILT_CYC), .CNT_W(CNT_W), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .mcu_btn  (btn),
      .mcu_str  (str),
      .mcu_img  (img),
      .game_over(go),
      .move_l   (move_l),
      .move_r   (move_r),
      .run      (run),
      .show_game(show_game),
      .gstate   (gstate)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model state: per-key input history, filtered level, block flag.
   logic [15:0] m_hist  [4];
   logic        m_filt  [4];
   logic        m_filt_p[4];
   logic        m_blk   [4];
   logic        m_act   [2];
   int          m_pt    [2];
   int          m_n = 0;
   logic [1:0]  m_st;
   logic        m_show;
   logic [5:0]  m_exp;

   function automatic logic [5:0] obs();
      return {move_l, move_r, run, show_game, gstate};
   endfunction

   task automatic check(input string nm, input logic [5:0] got, input logic [5:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s edge=%0d got=%b want=%b", nm, m_n, got, expv);
      end
   endtask

   // One clock edge of the model, from the rules: levels need FILT_CYC equal
   // samples two flops late, edges act one cycle later, repeats at fixed offsets.
   task automatic model_edge();
      logic [3:0] in, rise;
      logic [1:0] mv;
      logic       both, in_run, press, win, show_n;
      logic [1:0] st_n;
      int         d;
      in = {img, str, btn};
      m_n++;
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_hist[k]   = '0;
            m_filt[k]   = 1'b0;
            m_filt_p[k] = 1'b0;
            m_blk[k]    = in[k];
         end
         m_act[0] = 1'b0;
         m_act[1] = 1'b0;
         m_st     = 2'd0;
         m_show   = 1'b0;
         m_exp    = '0;
         return;
      end
      for (int k = 0; k < 4; k++) rise[k] = m_filt[k] && !m_filt_p[k] && !m_blk[k];
      both   = m_filt[0] && m_filt[1];
      in_run = (m_st == 2'd1);
      mv     = '0;
      for (int k = 0; k < 2; k++) begin
         press = rise[k] && in_run && !both;
         if (!in_run || !m_filt[k] || both) begin
            m_act[k] = 1'b0;
         end else if (press) begin
            m_act[k] = 1'b1;
            m_pt[k]  = m_n;
         end else if (m_act[k] && RPT_EN) begin
            d = m_n - m_pt[k];
            if (d == int'(RPT_DLY) ||
                (d > int'(RPT_DLY) && ((d - int'(RPT_DLY)) % int'(RPT_PER)) == 0))
               mv[k] = 1'b1;
         end
         if (press) mv[k] = 1'b1;
      end
      st_n   = m_st;
      show_n = rise[3] ? !m_show : m_show;
      case (m_st)
         2'd0: if (rise[2]) begin st_n = 2'd1; show_n = 1'b1; end
         2'd1: if (go) st_n = 2'd3; else if (rise[2]) st_n = 2'd2;
         2'd2: if (go) st_n = 2'd3; else if (rise[2]) st_n = 2'd1;
         default: if (rise[2]) begin st_n = 2'd0; show_n = 1'b0; end
      endcase
      for (int k = 0; k < 4; k++) begin
         m_hist[k] = {m_hist[k][14:0], in[k]};
         win = 1'b1;
         for (int j = 2; j <= int'(FILT_CYC) + 1; j++)
            if (m_hist[k][j] == m_filt[k]) win = 1'b0;
         m_filt_p[k] = m_filt[k];
         if (win) m_filt[k] = !m_filt[k];
         m_blk[k] = m_blk[k] && in[k];
      end
      m_st   = st_n;
      m_show = show_n;
      m_exp  = {mv[0], mv[1], (st_n == 2'd1), show_n, st_n};
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model", obs(), m_exp);
   endtask

   task automatic run_cyc(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  btn;
      logic        str;
      logic        img;
      logic        go;
      int unsigned ncyc;
      logic [5:0]  expv;   // {move_l, move_r, run, show_game, gstate}
   } vec_t;

   localparam int NV = 25;
   vec_t vt[NV];

   int hb, hs, hi;
   logic exp_bit;

   initial begin
      rst = 1'b1; btn = 2'b00; str = 1'b0; img = 1'b0; go = 1'b0;

      vt[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2,  6'b000000};
      vt[1]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 6,  6'b000000};
      vt[2]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1,  6'b001101};
      vt[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b001101};
      vt[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 7,  6'b000110};
      vt[5]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b000110};
      vt[6]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 7,  6'b001101};
      vt[7]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b001101};
      vt[8]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 12, 6'b001101};
      vt[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b001101};
      vt[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2,  6'b001101};
      vt[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 10, 6'b001101};
      vt[12] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 6,  6'b001101};
      vt[13] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1,  6'b000111};
      vt[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8,  6'b000111};
      vt[15] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 7,  6'b000000};
      vt[16] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b000000};
      vt[17] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7,  6'b000100};
      vt[18] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b000100};
      vt[19] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7,  6'b000000};
      vt[20] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b000000};
      vt[21] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7,  6'b000100};
      vt[22] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b000100};
      vt[23] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 7,  6'b001101};
      vt[24] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8,  6'b001101};

      for (int i = 0; i < NV; i++) begin
         rst = vt[i].rst; btn = vt[i].btn; str = vt[i].str;
         img = vt[i].img; go = vt[i].go;
         run_cyc(vt[i].ncyc);
         check($sformatf("vec%0d", i), obs(), vt[i].expv);
      end

      // Held left key in RUN: press pulse, then repeats only with auto-repeat.
      btn = 2'b01;
      for (int k = 1; k <= 50; k++) begin
         step();
         exp_bit = (k == 7) || (RPT_EN && (k == 27 || k == 35 || k == 43));
         check($sformatf("hold_l_k%0d", k), {4'b0, move_l, move_r}, {4'b0, exp_bit, 1'b0});
      end
      btn = 2'b00;
      run_cyc(8);

      // Reset in mid-hold, key kept held afterwards.
      btn = 2'b01;
      run_cyc(30);
      rst = 1'b1;
      step();
      check("rst_mid_hold", obs(), 6'b000000);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         check("held_thru_rst", obs(), 6'b000000);
      end
      btn = 2'b00;
      run_cyc(8);
      str = 1'b1;
      run_cyc(7);
      check("rerun", obs(), 6'b001101);
      str = 1'b0;
      run_cyc(8);
      btn = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("fresh_press_k%0d", k), {5'b0, move_l}, {5'b0, (k == 7)});
      end
      btn = 2'b00;
      run_cyc(8);

      // Right key pressed in PAUSE and still held when RUN resumes.
      str = 1'b1;
      run_cyc(7);
      check("pause", obs(), 6'b000110);
      str = 1'b0;
      run_cyc(8);
      btn = 2'b10;
      run_cyc(10);
      str = 1'b1;
      run_cyc(7);
      check("resume_held", obs(), 6'b001101);
      str = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         check("no_pulse_late_run", {5'b0, move_r}, 6'b000000);
      end
      btn = 2'b00;
      run_cyc(8);

      // Random stimulus against the model.
      hb = 0; hs = 0; hi = 0;
      for (int c = 0; c < 4000; c++) begin
         if (hb == 0) begin btn = 2'($urandom_range(0, 3)); hb = $urandom_range(1, 50); end
         else hb--;
         if (hs == 0) begin str = ~str; hs = $urandom_range(1, 40); end
         else hs--;
         if (hi == 0) begin img = ~img; hi = $urandom_range(1, 60); end
         else hi--;
         go  = ($urandom_range(0, 63) == 0);
         rst = ($urandom_range(0, 1499) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
